// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_pkg
// Description : Shared types for the CPU memory-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_bus_pkg;

    localparam int WAIT_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_DATA  = 3'd1,
        ST_STEP  = 3'd2,
        ST_HALT  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between CPU instruction fetch and data
//               access; single-steps the CPU through clk_enable.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import cpu_bus_pkg::*;
#(
    parameter logic [WAIT_CNT_W-1:0] WAIT_TIMEOUT = 16'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    input  logic        active,
    output logic        clk_enable,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic        timeout_error
);

    localparam logic [WAIT_CNT_W-1:0] c_cnt_one = WAIT_CNT_W'(1);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_fetch_done;
    logic                  w_fetch_done_next;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_cnt_next;
    logic [WAIT_CNT_W-1:0] w_wait_inc;
    logic [31:0]           r_instr;
    logic [31:0]           r_data;
    logic                  r_timeout;
    logic                  w_access;
    logic                  w_complete;
    logic                  w_timeout;
    logic                  w_data_rd;

    // r_fetch_done distinguishes the issuing phase of FETCH from DECIDE.
    assign w_access   = ((r_state == ST_FETCH) && !r_fetch_done) || (r_state == ST_DATA);
    assign w_complete = w_access && !mem_waitrequest;
    assign w_data_rd  = data_read && !data_write;
    assign w_wait_inc = r_wait_cnt + c_cnt_one;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_FETCH;
            r_fetch_done <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_fetch_done <= w_fetch_done_next;
            r_wait_cnt   <= w_wait_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr   <= '0;
            r_data    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_complete && (r_state == ST_FETCH)) begin
                r_instr <= mem_readdata;
            end
            if (w_complete && (r_state == ST_DATA) && w_data_rd) begin
                r_data <= mem_readdata;
            end
            if (w_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // The wait counter only survives while an access is stalled, so it is
    // implicitly zero at the start of every access.
    always_comb begin
        w_state_next      = r_state;
        w_fetch_done_next = r_fetch_done;
        w_wait_cnt_next   = '0;
        w_timeout         = 1'b0;
        if (w_access && mem_waitrequest) begin
            if ((WAIT_TIMEOUT != '0) && (w_wait_inc == WAIT_TIMEOUT)) begin
                w_timeout         = 1'b1;
                w_state_next      = ST_ERROR;
                w_fetch_done_next = 1'b0;
            end else begin
                w_wait_cnt_next = w_wait_inc;
            end
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (!r_fetch_done) begin
                        w_fetch_done_next = 1'b1;
                    end else begin
                        w_fetch_done_next = 1'b0;
                        w_state_next      = (data_read || data_write) ? ST_DATA : ST_STEP;
                    end
                end
                ST_DATA:  w_state_next = ST_STEP;
                ST_STEP:  w_state_next = active ? ST_FETCH : ST_HALT;
                default:  w_state_next = r_state;
            endcase
        end
    end

    // Reset gates the strobes combinationally so an abandoned store never
    // reaches memory, and holds clk_enable high to reset the CPU.
    always_comb begin
        mem_address   = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_writedata = '0;
        clk_enable    = reset;
        if (!reset) begin
            case (r_state)
                ST_FETCH: begin
                    mem_address = instr_address;
                    mem_read    = !r_fetch_done;
                end
                ST_DATA: begin
                    mem_address   = data_address;
                    mem_read      = w_data_rd;
                    mem_write     = data_write;
                    mem_writedata = data_writedata;
                end
                ST_STEP:  clk_enable = 1'b1;
                default:  clk_enable = 1'b0;
            endcase
        end
    end

    assign instr_readdata = r_instr;
    assign data_readdata  = r_data;
    assign timeout_error  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        active;
    logic        clk_enable;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        timeout_error;

    int n_tests;
    int n_fail;

    mem_port_arbiter #(
        .WAIT_TIMEOUT(16'd8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .active         (active),
        .clk_enable     (clk_enable),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_waitrequest(mem_waitrequest),
        .mem_readdata   (mem_readdata),
        .timeout_error  (timeout_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        reset           = 1'b1;
        active          = 1'b1;
        instr_address   = 32'hBFC0_0000;
        data_address    = '0;
        data_read       = 1'b0;
        data_write      = 1'b0;
        data_writedata  = '0;
        mem_waitrequest = 1'b0;
        mem_readdata    = '0;

        cyc(); cyc(); #1;
        chk1 ("rst_clk_en",   clk_enable, 1'b1);
        chk1 ("rst_mem_read", mem_read, 1'b0);
        chk1 ("rst_mem_write", mem_write, 1'b0);
        chk32("rst_instr",    instr_readdata, 32'h0);
        chk32("rst_data",     data_readdata, 32'h0);
        chk1 ("rst_timeout",  timeout_error, 1'b0);

        // addu at 0xBFC00000, zero-wait memory
        cyc(); reset = 1'b0; mem_readdata = 32'h0085_1021; #1;
        chk1 ("f0_read",   mem_read, 1'b1);
        chk32("f0_addr",   mem_address, 32'hBFC0_0000);
        chk1 ("f0_clk_en", clk_enable, 1'b0);
        cyc(); #1;
        chk1 ("d0_read",   mem_read, 1'b0);
        chk32("d0_instr",  instr_readdata, 32'h0085_1021);
        chk1 ("d0_clk_en", clk_enable, 1'b0);
        cyc(); #1;
        chk1 ("s0_clk_en", clk_enable, 1'b1);
        chk1 ("s0_read",   mem_read, 1'b0);

        // lw from 0x1000 with two wait cycles: 6-cycle instruction
        cyc(); instr_address = 32'hBFC0_0004; mem_readdata = 32'h8C88_0000; #1;
        chk32("f1_addr",   mem_address, 32'hBFC0_0004);
        chk1 ("f1_read",   mem_read, 1'b1);
        chk1 ("f1_clk_en", clk_enable, 1'b0);
        cyc(); data_read = 1'b1; data_address = 32'h0000_1000; #1;
        chk32("d1_instr",  instr_readdata, 32'h8C88_0000);
        chk1 ("d1_clk_en", clk_enable, 1'b0);
        cyc(); mem_waitrequest = 1'b1; #1;
        chk1 ("lw_w1_read",  mem_read, 1'b1);
        chk1 ("lw_w1_write", mem_write, 1'b0);
        chk32("lw_w1_addr",  mem_address, 32'h0000_1000);
        cyc(); #1;
        chk32("lw_w2_addr",   mem_address, 32'h0000_1000);
        chk1 ("lw_w2_read",   mem_read, 1'b1);
        chk1 ("lw_w2_clk_en", clk_enable, 1'b0);
        cyc(); mem_waitrequest = 1'b0; mem_readdata = 32'hDEAD_BEEF; #1;
        chk1 ("lw_done_read",   mem_read, 1'b1);
        chk1 ("lw_done_clk_en", clk_enable, 1'b0);
        cyc(); #1;
        chk1 ("s1_clk_en", clk_enable, 1'b1);
        chk32("s1_data",   data_readdata, 32'hDEAD_BEEF);

        // sw 0x12345678 to 0x2000 with data_read also high: write wins
        cyc(); data_read = 1'b0; instr_address = 32'hBFC0_0008; mem_readdata = 32'hAC89_0000; #1;
        chk1 ("f2_read",  mem_read, 1'b1);
        chk32("f2_addr",  mem_address, 32'hBFC0_0008);
        cyc(); data_write = 1'b1; data_read = 1'b1; data_address = 32'h0000_2000;
        data_writedata = 32'h1234_5678; #1;
        chk1 ("d2_write", mem_write, 1'b0);
        cyc(); mem_readdata = 32'h5555_5555; #1;
        chk1 ("sw_write", mem_write, 1'b1);
        chk1 ("sw_read",  mem_read, 1'b0);
        chk32("sw_wdata", mem_writedata, 32'h1234_5678);
        chk32("sw_addr",  mem_address, 32'h0000_2000);
        cyc(); #1;
        chk1 ("s2_clk_en", clk_enable, 1'b1);
        chk1 ("s2_write",  mem_write, 1'b0);
        chk32("s2_data",   data_readdata, 32'hDEAD_BEEF);

        // jump to 0: active falls, STEP then HALT
        cyc(); data_write = 1'b0; data_read = 1'b0; instr_address = 32'hBFC0_000C;
        mem_readdata = 32'h0800_0000; #1;
        chk1 ("f3_read", mem_read, 1'b1);
        cyc(); active = 1'b0; #1;
        chk1 ("d3_clk_en", clk_enable, 1'b0);
        cyc(); #1;
        chk1 ("s3_clk_en", clk_enable, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(); instr_address = 32'h0; #1;
            chk1 ("halt_read",   mem_read, 1'b0);
            chk1 ("halt_write",  mem_write, 1'b0);
            chk1 ("halt_clk_en", clk_enable, 1'b0);
        end

        // restart, then reset during a stalled store
        cyc(); reset = 1'b1; active = 1'b1; #1;
        chk1 ("rst2_clk_en", clk_enable, 1'b1);
        cyc(); reset = 1'b0; instr_address = 32'hBFC0_0000; mem_readdata = 32'hAC8A_0004; #1;
        chk1 ("f4_read", mem_read, 1'b1);
        cyc(); data_write = 1'b1; data_address = 32'h0000_2000; data_writedata = 32'hCAFE_F00D; #1;
        cyc(); mem_waitrequest = 1'b1; #1;
        chk1 ("stall_write", mem_write, 1'b1);
        cyc(); reset = 1'b1; #1;
        chk1 ("abort_write", mem_write, 1'b0);
        cyc(); #1;
        chk1 ("rst3_write",   mem_write, 1'b0);
        chk1 ("rst3_read",    mem_read, 1'b0);
        chk32("rst3_instr",   instr_readdata, 32'h0);
        chk32("rst3_data",    data_readdata, 32'h0);
        chk1 ("rst3_timeout", timeout_error, 1'b0);
        chk1 ("rst3_clk_en",  clk_enable, 1'b1);

        // fetch right after reset, waitrequest held high until timeout
        cyc(); reset = 1'b0; data_write = 1'b0; #1;
        chk1 ("to_w1_read", mem_read, 1'b1);
        chk32("to_w1_addr", mem_address, 32'hBFC0_0000);
        for (int i = 2; i <= 8; i++) begin
            cyc(); #1;
            chk1 ("to_wait_read",    mem_read, 1'b1);
            chk1 ("to_wait_timeout", timeout_error, 1'b0);
        end
        cyc(); #1;
        chk1 ("to_flag",   timeout_error, 1'b1);
        chk1 ("to_read",   mem_read, 1'b0);
        chk1 ("to_clk_en", clk_enable, 1'b0);
        mem_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk1 ("err_clk_en",  clk_enable, 1'b0);
            chk1 ("err_read",    mem_read, 1'b0);
            chk1 ("err_timeout", timeout_error, 1'b1);
        end
        cyc(); reset = 1'b1; #1;
        cyc(); #1;
        chk1 ("rst4_timeout", timeout_error, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
